// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle CPU core with a 16-bit instruction word, program-load port,
// branches and a terminal HALT state. Owns its instruction memory, data memory and register file.
module cpu_core_param #(
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 16,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [15:0]                   prog_data,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic [DATA_W-1:0]             result,
    output logic                          zero,
    output logic                          carry,
    output logic                          negative,
    output logic                          halted
);

    localparam int PC_W = $clog2(IMEM_DEPTH);
    localparam int RA_W = $clog2(NUM_REGS);
    localparam int DA_W = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_LD   = 4'h7,
        OP_ST   = 4'h8,
        OP_JMP  = 4'h9,
        OP_BZ   = 4'hA,
        OP_HALT = 4'hB
    } op_t;

    logic [15:0]       r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    state_t            r_state;
    logic [15:0]       r_instr;
    logic [DATA_W:0]   r_alu;
    logic [DATA_W-1:0] r_ld_data;

    logic [3:0]        w_op;
    logic [RA_W-1:0]   w_rd;
    logic [RA_W-1:0]   w_rs;
    logic [RA_W-1:0]   w_rt;
    logic [7:0]        w_imm8;
    logic [DA_W-1:0]   w_daddr;
    logic [PC_W-1:0]   w_jaddr;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_alu;

    assign w_op    = r_instr[15:12];
    assign w_rd    = r_instr[8 +: RA_W];
    assign w_rs    = r_instr[4 +: RA_W];
    assign w_rt    = r_instr[0 +: RA_W];
    assign w_imm8  = r_instr[7:0];
    assign w_daddr = w_imm8[0 +: DA_W];
    assign w_jaddr = w_imm8[0 +: PC_W];
    assign w_a     = r_regs[w_rs];
    assign w_b     = r_regs[w_rt];

    // Bit DATA_W of the widened result is the carry (ADD) or borrow (SUB); zero for logic ops.
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = {1'b0, w_a} + {1'b0, w_b};
            OP_SUB:  w_alu = {1'b0, w_a} - {1'b0, w_b};
            OP_AND:  w_alu = {1'b0, w_a & w_b};
            OP_OR:   w_alu = {1'b0, w_a | w_b};
            OP_XOR:  w_alu = {1'b0, w_a ^ w_b};
            OP_LDI:  w_alu = {1'b0, DATA_W'(w_imm8)};
            default: w_alu = '0;
        endcase
    end

    // Program loading is independent of reset so the image can be written while the core is held.
    always_ff @(posedge clk) begin
        if (prog_we) r_imem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (r_state == S_EXEC) begin
            r_ld_data <= r_dmem[w_daddr];
            if (w_op == OP_ST) r_dmem[w_daddr] <= r_regs[w_rd];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_instr  <= '0;
            r_alu    <= '0;
            pc       <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            halted   <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_instr <= r_imem[pc];
                    pc      <= pc + 1'b1;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    if (w_op == OP_JMP || (w_op == OP_BZ && zero)) pc <= w_jaddr;
                    r_state <= (w_op == OP_HALT) ? S_HALTED : S_WB;
                end
                S_WB: begin
                    case (w_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            r_regs[w_rd] <= r_alu[DATA_W-1:0];
                            result       <= r_alu[DATA_W-1:0];
                            zero         <= (r_alu[DATA_W-1:0] == '0);
                            carry        <= r_alu[DATA_W];
                            negative     <= r_alu[DATA_W-1];
                        end
                        OP_LDI: begin
                            r_regs[w_rd] <= r_alu[DATA_W-1:0];
                            result       <= r_alu[DATA_W-1:0];
                        end
                        OP_LD: begin
                            r_regs[w_rd] <= r_ld_data;
                            result       <= r_ld_data;
                        end
                        default: ;
                    endcase
                    r_state <= S_FETCH;
                end
                S_HALTED: halted <= 1'b1;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_param.sv
// Scoreboard bench for cpu_core_param: stimulus queues expected end-of-program state,
// monitors compare when each core raises halted.
module tb_cpu_core_param;

    logic        clk = 1'b0;
    logic        reset1, prog_we1, zero1, carry1, neg1, halted1;
    logic [7:0]  prog_addr1, pc1, result1;
    logic [15:0] prog_data1;

    logic        reset2, prog_we2, zero2, carry2, neg2, halted2;
    logic [3:0]  prog_addr2, pc2;
    logic [15:0] prog_data2, result2;

    always #5 clk = ~clk;

    cpu_core_param #(.DATA_W(8), .NUM_REGS(16), .IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut1 (
        .clk(clk), .reset(reset1), .prog_we(prog_we1), .prog_addr(prog_addr1),
        .prog_data(prog_data1), .pc(pc1), .result(result1), .zero(zero1),
        .carry(carry1), .negative(neg1), .halted(halted1)
    );

    cpu_core_param #(.DATA_W(16), .NUM_REGS(16), .IMEM_DEPTH(16), .DMEM_DEPTH(256)) dut2 (
        .clk(clk), .reset(reset2), .prog_we(prog_we2), .prog_addr(prog_addr2),
        .prog_data(prog_data2), .pc(pc2), .result(result2), .zero(zero2),
        .carry(carry2), .negative(neg2), .halted(halted2)
    );

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        n;
        logic [7:0]  pc;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1, e2;
    logic [15:0] prog[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic        prev_h1  = 1'b0;
    logic        prev_h2  = 1'b0;

    function automatic logic [15:0] rr(input logic [3:0] op, rd, rs, rt);
        return {op, rd, rs, rt};
    endfunction

    function automatic logic [15:0] ri(input logic [3:0] op, rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (halted1 === 1'b1 && !prev_h1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL dut1_unexpected_halt: got halt, expected none");
            end else begin
                e1 = q1.pop_front();
                chk({e1.name, ".result"}, 32'(result1), 32'(e1.res));
                chk({e1.name, ".zero"}, 32'(zero1), 32'(e1.z));
                chk({e1.name, ".carry"}, 32'(carry1), 32'(e1.c));
                chk({e1.name, ".neg"}, 32'(neg1), 32'(e1.n));
                chk({e1.name, ".pc"}, 32'(pc1), 32'(e1.pc));
            end
        end
        prev_h1 = halted1;
    end

    always @(negedge clk) begin
        if (halted2 === 1'b1 && !prev_h2) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL dut2_unexpected_halt: got halt, expected none");
            end else begin
                e2 = q2.pop_front();
                chk({e2.name, ".result"}, 32'(result2), 32'(e2.res));
                chk({e2.name, ".zero"}, 32'(zero2), 32'(e2.z));
                chk({e2.name, ".carry"}, 32'(carry2), 32'(e2.c));
                chk({e2.name, ".neg"}, 32'(neg2), 32'(e2.n));
                chk({e2.name, ".pc"}, 32'(pc2), 32'(e2.pc));
            end
        end
        prev_h2 = halted2;
    end

    task automatic load(input int sel);
        if (sel == 1) reset1 = 1'b1; else reset2 = 1'b1;
        @(negedge clk);
        foreach (prog[i]) begin
            if (sel == 1) begin
                prog_we1 = 1'b1; prog_addr1 = 8'(i); prog_data1 = prog[i];
            end else begin
                prog_we2 = 1'b1; prog_addr2 = 4'(i); prog_data2 = prog[i];
            end
            @(negedge clk);
        end
        prog_we1 = 1'b0;
        prog_we2 = 1'b0;
    endtask

    task automatic run(input int sel, input string name, output int cyc);
        logic h;
        if (sel == 1) reset1 = 1'b0; else reset2 = 1'b0;
        cyc = 0;
        h   = 1'b0;
        while (!h && cyc < 300) begin
            @(negedge clk);
            cyc++;
            h = (sel == 1) ? halted1 : halted2;
        end
        chk({name, ".halt_seen"}, 32'(h), 32'd1);
        @(negedge clk);
    endtask

    task automatic prog_run1(input string name, input logic [15:0] r, input logic z, c, n,
                             input logic [7:0] p);
        int cyc;
        load(1);
        q1.push_back('{name, r, z, c, n, p});
        run(1, name, cyc);
    endtask

    initial begin
        int cyc;
        reset1 = 1'b1; reset2 = 1'b1;
        prog_we1 = 1'b0; prog_we2 = 1'b0;
        prog_addr1 = '0; prog_addr2 = '0; prog_data1 = '0; prog_data2 = '0;
        repeat (2) @(negedge clk);
        chk("reset.pc", 32'(pc1), 0);
        chk("reset.result", 32'(result1), 0);
        chk("reset.flags", {29'd0, zero1, carry1, neg1}, 0);
        chk("reset.halted", 32'(halted1), 0);

        // Basic add/store; HALT is entered after 14 edges, halted registers on the 15th.
        prog = {ri(6, 1, 8'h04), ri(6, 2, 8'h08), rr(1, 3, 1, 2), ri(8, 3, 8'h03), 16'hB000};
        load(1);
        q1.push_back('{"t1_add", 16'd12, 1'b0, 1'b0, 1'b0, 8'd5});
        run(1, "t1_add", cyc);
        chk("t1.halt_cycles", cyc, 15);
        repeat (3) @(negedge clk);
        chk("t1.pc_hold", 32'(pc1), 5);
        chk("t1.halted_hold", 32'(halted1), 1);

        prog = {ri(7, 4, 8'h03), 16'hB000};
        prog_run1("t1_dmem3", 16'd12, 1'b0, 1'b0, 1'b0, 8'd2);

        prog = {ri(6, 1, 8'hFF), ri(6, 2, 8'h01), rr(1, 3, 1, 2), 16'hB000};
        prog_run1("t2_add_wrap", 16'h00, 1'b1, 1'b1, 1'b0, 8'd4);

        prog = {ri(6, 5, 8'h03), ri(6, 6, 8'h05), rr(2, 7, 5, 6), 16'hB000};
        prog_run1("t2_sub_borrow", 16'hFE, 1'b0, 1'b1, 1'b1, 8'd4);

        prog = {ri(6, 1, 8'h01), rr(2, 2, 1, 1), ri(4'hA, 0, 8'h06), ri(6, 3, 8'hAA),
                16'hB000, 16'h0000, ri(6, 3, 8'h55), 16'hB000};
        prog_run1("t3_bz_taken", 16'h55, 1'b1, 1'b0, 1'b0, 8'd8);

        prog[1] = rr(1, 2, 1, 1);
        prog_run1("t3_bz_not", 16'hAA, 1'b0, 1'b0, 1'b0, 8'd5);

        prog = {ri(6, 2, 8'h80), rr(4, 3, 2, 2), ri(6, 1, 8'h3C), ri(8, 1, 8'h10),
                ri(6, 1, 8'h00), ri(7, 9, 8'h10), 16'hB000};
        prog_run1("t4_ldst", 16'h3C, 1'b0, 1'b0, 1'b1, 8'd7);

        // Asynchronous reset in the middle of the ADD's EXEC cycle.
        prog = {ri(6, 1, 8'hFF), ri(6, 2, 8'h01), rr(1, 3, 1, 2), 16'hB000};
        load(1);
        reset1 = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("t5.pre_pc", 32'(pc1), 3);
        chk("t5.pre_result", 32'(result1), 1);
        reset1 = 1'b1;
        #1;
        chk("t5.async_pc", 32'(pc1), 0);
        chk("t5.async_result", 32'(result1), 0);
        chk("t5.async_flags", {29'd0, zero1, carry1, neg1}, 0);
        @(negedge clk);
        q1.push_back('{"t5_rerun", 16'h00, 1'b1, 1'b1, 1'b0, 8'd4});
        run(1, "t5_rerun", cyc);

        // 16-bit core with 16-word imem: jump target 0x14 wraps to 4.
        prog = {ri(6, 1, 8'hFF), ri(6, 2, 8'h01), ri(9, 0, 8'h14), 16'hB000,
                rr(1, 3, 1, 2), 16'hB000};
        load(2);
        q2.push_back('{"t6_w16", 16'h0100, 1'b0, 1'b0, 1'b0, 8'd6});
        run(2, "t6_w16", cyc);

        chk("queue1_drained", q1.size(), 0);
        chk("queue2_drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
Parametrised multi-cycle CPU core, next generation of the team's 8-bit CPU. Data width, register count and memory depths are parameters. Adds a 16-bit instruction word, a program-load port, branches and a HALT state. The core owns its instruction memory, data memory and register file; the result bus and the zero/carry/negative flags are exported as on the 8-bit CPU.

Parameters:
DATA_W, 8, datapath/register/data-memory word width (>=8)
NUM_REGS, 16, register count (power of two, 2..16)
IMEM_DEPTH, 256, instruction words (power of two, <=256)
DMEM_DEPTH, 256, data words (power of two, <=256)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
prog_we  input  1  instruction-memory write strobe
prog_addr  input  clog2(IMEM_DEPTH)  write address
prog_data  input  16  instruction word to write
pc  output  clog2(IMEM_DEPTH)  current program counter
result  output  DATA_W  last value written to a register
zero  output  1  ALU result == 0
carry  output  1  carry out (ADD) / borrow (SUB)
negative  output  1  ALU result MSB
halted  output  1  core stopped on HALT

Behaviour:
- Reset (async, any state): pc=0, state=FETCH, all registers=0, result=0, zero=carry=negative=0, halted=0. Memory contents are preserved.
- Instruction format: op[15:12], rd[11:8], rs[7:4], rt[3:0], imm8[7:0].
- Register indices are taken modulo NUM_REGS. imm8 addresses are taken modulo the depth of the target memory.
- FSM, 3 cycles per instruction:
  - FETCH: latch instr = imem[pc]; pc <= pc+1, wrapping from IMEM_DEPTH-1 to 0. Go to EXEC.
  - EXEC: compute ALU result, issue the data-memory read or write, resolve branches (pc <= imm8 on a taken branch). Go to WB; go to HALTED on HALT.
  - WB: register write, result update, flag update. Go to FETCH.
  - HALTED: terminal; halted=1, no state changes until reset.
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs+rt.
  - 2 SUB rd=rs-rt.
  - 3 AND, 4 OR, 5 XOR: rd=rs op rt.
  - 6 LDI rd=zero-extended imm8.
  - 7 LD rd=dmem[imm8], with a synchronous read issued in EXEC and data captured in WB.
  - 8 ST dmem[imm8]=rd, written at the end of EXEC.
  - 9 JMP pc=imm8.
  - A BZ pc=imm8 if zero==1 (current flag value, before this instruction).
  - B HALT.
  - C-F behave as NOP.
- Arithmetic is modulo 2^DATA_W.
  - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB: carry = 1 when rs < rt unsigned.
  - Logic ops: carry = 0.
- Flags update only in WB of ALU ops 1-5: zero = (value==0), negative = value[DATA_W-1]. LDI, LD, ST, NOP, JMP, BZ and HALT leave flags unchanged.
- result updates in WB of every register-writing op (1-7) to the written value; otherwise it holds.
- Register write in WB and register read in EXEC never overlap (multi-cycle design), so no forwarding is needed.
- prog_we writes imem[prog_addr] on the clock edge, in any state, including while reset is asserted. A write to address pc lands before the next FETCH reads it only if it occurs before that FETCH edge.
- Jumps to addresses >= IMEM_DEPTH wrap modulo the depth. Running off the end of imem wraps pc to 0.

Test Plan:
1. DATA_W=8: load LDI R1,4; LDI R2,8; ADD R3,R1,R2; ST R3,3; HALT, then release reset -> R3=12, dmem[3]=12, result=12, zero=0, carry=0; halted rises 15 cycles after reset release and pc holds.
2. LDI R1,0xFF; LDI R2,1; ADD R3,R1,R2 -> R3=0x00, zero=1, carry=1, negative=0. Then SUB R4,R2,R1 (wait, use LDI R5,3; LDI R6,5; SUB R7,R5,R6) -> R7=0xFE, carry=1, negative=1, zero=0.
3. Branch: LDI R1,1; SUB R2,R1,R1 (zero=1); BZ 6; LDI R3,0xAA; HALT; NOP; LDI R3,0x55; HALT -> R3=0x55. The same program with zero=0 beforehand (ADD instead of SUB) -> R3=0xAA.
4. LD/ST: ST R1,0x10 with R1=0x3C; LD R9,0x10 -> R9=0x3C, result=0x3C, flags unchanged from their prior values.
5. Assert reset asynchronously mid-EXEC of an ADD -> outputs and pc are 0 immediately, without waiting for a clock edge; imem is intact and the program reruns from address 0 after release.
6. DATA_W=16, IMEM_DEPTH=16: LDI R1,0xFF; LDI R2,1; ADD R3,R1,R2 -> R3=0x0100, carry=0. JMP 0x13 -> pc=3 (wrap modulo 16).
